// File: rtl/mole_game_core.sv
// Purpose: N-hole whack-a-mole engine: countdown, LFSR-driven waves of 1..2 moles, scoring, misses, game over.
// Latency: all outputs are registered; an input sampled on a clk edge is reflected right after that edge.
// Backpressure: none; tick_1hz/start/clear/hit_vec are single-cycle strobes consumed in the cycle they arrive.
module mole_game_core #(
    parameter int          N_MOLES       = 8,
    parameter int          TICKS_EASY    = 300_000_000,
    parameter int          TICKS_MED     = 200_000_000,
    parameter int          TICKS_HARD    = 100_000_000,
    parameter int          GAP_TICKS     = 25_000_000,
    parameter int          COUNTDOWN_SEC = 3,
    parameter int          GAME_SEC      = 30,
    parameter int          MAX_SCORE     = 99,
    parameter int          MAX_MISSES    = 5,
    parameter int          WRONG_PENALTY = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               start,
    input  logic               clear,
    input  logic [1:0]         level,
    input  logic [N_MOLES-1:0] hit_vec,
    output logic [N_MOLES-1:0] mole_led,
    output logic [7:0]         score,
    output logic [3:0]         misses,
    output logic [5:0]         sec_left,
    output logic [2:0]         state,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_SPAWN     = 3'd2,
        S_UP        = 3'd3,
        S_GAP       = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam logic [N_MOLES-1:0] ONE = {{(N_MOLES-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [15:0]        lfsr_q;
    logic [31:0]        timer_q, timer_d;
    logic [N_MOLES-1:0] mole_q, mole_d;
    logic [7:0]         score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic [5:0]         sec_q, sec_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic [N_MOLES-1:0] good, wrong, led_post, spawn_mask;
    logic [7:0]         idx1, idx2;
    logic [7:0]         score_net;
    logic [31:0]        wave_ticks;
    logic [3:0]         misses_inc;
    logic               miss_limit;
    int                 net;

    function automatic logic [4:0] popcnt(input logic [N_MOLES-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < N_MOLES; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1); advancing in every state makes waves depend on player timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Wave placement: second index is offset by 1..N-1 from the first so the two moles never coincide
    always_comb begin
        idx1       = 8'(int'(lfsr_q[7:0]) % N_MOLES);
        idx2       = 8'((int'(idx1) + 1 + (int'(lfsr_q[15:8]) % (N_MOLES - 1))) % N_MOLES);
        spawn_mask = ONE << idx1;
        if (lvl_q[1]) begin
            spawn_mask = spawn_mask | (ONE << idx2);
        end
        case (lvl_q)
            2'd0:    wave_ticks = 32'(TICKS_EASY);
            2'd1:    wave_ticks = 32'(TICKS_MED);
            default: wave_ticks = 32'(TICKS_HARD);
        endcase
    end

    // Hit classification and the netted, saturating score update
    always_comb begin
        good     = hit_vec & mole_q;
        wrong    = hit_vec & ~mole_q;
        led_post = mole_q & ~hit_vec;
        net      = int'(score_q) + int'(popcnt(good))
                 - (((WRONG_PENALTY != 0) && (wrong != '0)) ? 1 : 0);
        if (net < 0) begin
            score_net = 8'd0;
        end else if (net > MAX_SCORE) begin
            score_net = 8'(MAX_SCORE);
        end else begin
            score_net = 8'(net);
        end
        misses_inc = (misses_q == 4'hF) ? 4'hF : misses_q + 4'd1;
        miss_limit = (MAX_MISSES != 0) && (int'(misses_inc) >= MAX_MISSES);
    end

    // Next-state logic: phase FSM, then play-second expiry override, then clear override
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        timer_d  = timer_q;
        mole_d   = mole_q;
        score_d  = score_q;
        misses_d = misses_q;
        sec_d    = sec_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                sec_d = 6'd0;
                if (start) begin
                    lvl_d   = level;
                    sec_d   = 6'(COUNTDOWN_SEC);
                    state_d = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (tick_1hz) begin
                    if (sec_q == 6'd1) begin
                        sec_d   = 6'(GAME_SEC);
                        state_d = S_SPAWN;
                    end else begin
                        sec_d = sec_q - 6'd1;
                    end
                end
            end
            S_SPAWN: begin
                mole_d  = spawn_mask;
                timer_d = wave_ticks;
                state_d = S_UP;
            end
            S_UP: begin
                timer_d = timer_q - 32'd1;
                score_d = score_net;
                hit_d   = (good != '0);
                mole_d  = led_post;
                if (led_post == '0) begin
                    timer_d = 32'(GAP_TICKS);
                    state_d = S_GAP;
                end else if (timer_q <= 32'd1) begin
                    // One miss per expired wave, judged on what is still lit after this cycle's hits
                    misses_d = misses_inc;
                    miss_d   = 1'b1;
                    mole_d   = '0;
                    timer_d  = 32'(GAP_TICKS);
                    state_d  = miss_limit ? S_OVER : S_GAP;
                end
            end
            S_GAP: begin
                mole_d  = '0;
                timer_d = timer_q - 32'd1;
                if (timer_q <= 32'd1) begin
                    state_d = S_SPAWN;
                end
            end
            S_OVER: begin
                if (start) begin
                    score_d  = 8'd0;
                    misses_d = 4'd0;
                    lvl_d    = level;
                    sec_d    = 6'(COUNTDOWN_SEC);
                    state_d  = S_COUNTDOWN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Last play second beats wave events; a hit in the same cycle keeps its score and pulse
        if ((state_q == S_SPAWN || state_q == S_UP || state_q == S_GAP) && tick_1hz) begin
            if (sec_q == 6'd1) begin
                sec_d    = 6'd0;
                mole_d   = '0;
                miss_d   = 1'b0;
                misses_d = misses_q;
                state_d  = S_OVER;
            end else begin
                sec_d = sec_q - 6'd1;
            end
        end

        if (clear) begin
            score_d  = 8'd0;
            misses_d = 4'd0;
            mole_d   = '0;
            sec_d    = 6'd0;
            hit_d    = 1'b0;
            miss_d   = 1'b0;
            state_d  = S_IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lvl_q    <= 2'd0;
            timer_q  <= 32'd0;
            mole_q   <= '0;
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            sec_q    <= 6'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            timer_q  <= timer_d;
            mole_q   <= mole_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            sec_q    <= sec_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign mole_led   = mole_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign sec_left   = sec_q;
    assign state      = state_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = (state_q == S_OVER);

endmodule
